gearbox_param: RTL and testbench

GEARBOX_PARAM -- requirements
Module: gearbox_param

---
 rtl/gearbox_param.sv | 66 ++++++
 tb/tb_gearbox_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gearbox_param.sv
// gearbox_param: bit-level width converter from IN_W-bit writes to OUT_W-bit reads over a circular buffer.
module gearbox_param #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 20,
  parameter int BUF_W = 128
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     shift_in,
  input  logic [IN_W-1:0]          data_in,
  output logic                     full,
  input  logic                     shift_out,
  output logic                     valid_out,
  output logic [OUT_W-1:0]         data_out,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [$clog2(BUF_W):0]   level,
  output logic                     overflow_err,
  output logic                     underflow_err,
  input  logic                     clear_err
);
  localparam int AW = $clog2(BUF_W);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] IN_L  = LW'(IN_W);
  localparam logic [LW-1:0] OUT_L = LW'(OUT_W);
  localparam logic [LW-1:0] CAP_L = LW'(BUF_W - IN_W);
  logic [BUF_W-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q, cons, level_nx;
  logic             flush_pend, wr_en, rd_en;
  assign level = level_q;
  always_comb begin
    full      = (level_q > CAP_L) || flush_pend;
    valid_out = (level_q >= OUT_L) || (flush_pend && level_q != '0);
    cons      = (level_q >= OUT_L) ? OUT_L : level_q;
    wr_en     = shift_in && !full;
    rd_en     = shift_out && valid_out;
    level_nx  = level_q + (wr_en ? IN_L : '0) - (rd_en ? cons : '0);
    data_out  = '0;
    for (int i = 0; i < OUT_W; i++)
      data_out[i] = (LW'(i) < level_q) ? mem[rd_ptr + AW'(i)] : 1'b0;
  end
  always_ff @(posedge clk)
    if (wr_en)
      for (int i = 0; i < IN_W; i++)
        mem[wr_ptr + AW'(i)] <= data_in[i];
  // A flush whose drain completes on the very edge it arrives is finished at once rather than left pending on an empty buffer.
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_q       <= '0;
      flush_pend    <= 1'b0;
      flush_done    <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(IN_W);
      if (rd_en) rd_ptr <= rd_ptr + cons[AW-1:0];
      level_q       <= level_nx;
      flush_pend    <= flush_pend ? !(rd_en && level_nx == '0) : (flush && level_q != '0 && level_nx != '0);
      flush_done    <= (flush_pend && rd_en && level_nx == '0) || (flush && !flush_pend && (level_q == '0 || level_nx == '0));
      overflow_err  <= (shift_in && full) || (overflow_err && !clear_err);
      underflow_err <= (shift_out && !valid_out) || (underflow_err && !clear_err);
    end
endmodule

// File: tb/tb_gearbox_param.sv
// tb_gearbox_param: directed checks of gearbox_param with default 16->20 over 128 bits.
module tb_gearbox_param;
  logic        clk = 0, res_n = 0, shift_in = 0, shift_out = 0, flush = 0, clear_err = 0;
  logic [15:0] data_in = 0;
  logic        full, valid_out, flush_done, overflow_err, underflow_err;
  logic [19:0] data_out;
  logic [7:0]  level;
  int          checks = 0, errors = 0;
  logic [15:0] sw [5] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'h3210};
  logic [19:0] sr [4] = '{20'h43210, 20'h98765, 20'hEDCBA, 20'h3210F};
  bit          q [$];
  logic [15:0] w;
  logic [19:0] e;
  bit          rdm;

  always #5 clk = ~clk;

  gearbox_param dut (
    .clk(clk), .res_n(res_n), .shift_in(shift_in), .data_in(data_in), .full(full),
    .shift_out(shift_out), .valid_out(valid_out), .data_out(data_out), .flush(flush),
    .flush_done(flush_done), .level(level), .overflow_err(overflow_err),
    .underflow_err(underflow_err), .clear_err(clear_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    res_n = 0; shift_in = 0; shift_out = 0; flush = 0; clear_err = 0;
    #3;
    @(negedge clk);
    res_n = 1;
  endtask

  task automatic wr(input logic [15:0] d);
    shift_in = 1; data_in = d;
    tick;
    shift_in = 0;
  endtask

  task automatic rd;
    shift_out = 1;
    tick;
    shift_out = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_fdone"}, flush_done, 0);
    chk({tag, "_ovf"}, overflow_err, 0);
    chk({tag, "_unf"}, underflow_err, 0);
  endtask

  initial begin
    #2;
    chk_reset_state("rst");
    do_reset;

    // stream
    for (int k = 0; k < 5; k++) wr(sw[k]);
    chk("stream_level", level, 80);
    for (int k = 0; k < 4; k++) begin
      chk("stream_valid", valid_out, 1);
      chk("stream_data", data_out, sr[k]);
      rd;
    end
    chk("stream_end_valid", valid_out, 0);
    chk("stream_end_level", level, 0);

    // simultaneous write and read at level 20
    do_reset;
    for (int k = 0; k < 5; k++) wr(sw[k]);
    for (int k = 0; k < 3; k++) rd;
    chk("sim_pre_level", level, 20);
    chk("sim_pre_data", data_out, 20'h3210F);
    shift_in = 1; data_in = 16'hAAAA; shift_out = 1;
    tick;
    shift_in = 0; shift_out = 0;
    chk("sim_level", level, 16);
    chk("sim_valid", valid_out, 0);
    chk("sim_low_bits", data_out[15:0], 16'hAAAA);

    // full and overflow
    do_reset;
    for (int k = 0; k < 8; k++) wr(16'(16'h1111 * (k + 1)));
    chk("full_level", level, 128);
    chk("full_flag", full, 1);
    chk("full_ovf_pre", overflow_err, 0);
    wr(16'hDEAD);
    chk("ovf_level", level, 128);
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_data", data_out, 20'h21111);
    shift_in = 1; clear_err = 1; data_in = 16'h5555;
    tick;
    shift_in = 0; clear_err = 0;
    chk("ovf_set_priority", overflow_err, 1);
    clear_err = 1;
    tick;
    clear_err = 0;
    chk("ovf_clear", overflow_err, 0);

    // flush
    do_reset;
    wr(16'hABCD);
    chk("fl_pre_valid", valid_out, 0);
    flush = 1;
    tick;
    flush = 0;
    chk("fl_valid", valid_out, 1);
    chk("fl_data", data_out, 20'h0ABCD);
    chk("fl_full", full, 1);
    chk("fl_done_early", flush_done, 0);
    rd;
    chk("fl_level", level, 0);
    chk("fl_done", flush_done, 1);
    chk("fl_valid_end", valid_out, 0);
    chk("fl_full_end", full, 0);
    tick;
    chk("fl_done_pulse", flush_done, 0);
    flush = 1;
    tick;
    flush = 0;
    chk("fl_empty_done", flush_done, 1);
    tick;
    chk("fl_empty_pulse", flush_done, 0);

    // wrap: 40 write/read pairs against a bit-queue model
    do_reset;
    q.delete();
    for (int k = 0; k < 40; k++) begin
      w = 16'(k * 16'h9E37 + 16'h1234);
      rdm = (q.size() >= 20);
      chk("wrap_valid", valid_out, rdm);
      if (rdm) begin
        for (int i = 0; i < 20; i++) e[i] = q[i];
        chk("wrap_data", data_out, e);
      end
      shift_in = 1; data_in = w; shift_out = rdm;
      tick;
      shift_in = 0; shift_out = 0;
      if (rdm) repeat (20) void'(q.pop_front());
      for (int i = 0; i < 16; i++) q.push_back(w[i]);
    end
    chk("wrap_level", level, q.size());

    // underflow
    do_reset;
    rd;
    chk("unf_flag", underflow_err, 1);
    chk("unf_level", level, 0);
    shift_out = 1; clear_err = 1;
    tick;
    shift_out = 0; clear_err = 0;
    chk("unf_set_priority", underflow_err, 1);
    clear_err = 1;
    tick;
    clear_err = 0;
    chk("unf_clear", underflow_err, 0);

    // asynchronous reset mid-stream
    do_reset;
    for (int k = 0; k < 4; k++) wr(sw[k]);
    chk("mid_level", level, 64);
    chk("mid_valid", valid_out, 1);
    #2 res_n = 0;
    #1;
    chk_reset_state("async_rst");
    @(negedge clk);
    res_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
